// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit CPU control sequencer.
//   - opcode values (ir[15:12])
//   - ALU function codes driven on alu_op
//   - control FSM state encoding
//   - instruction field bit positions
package cpu_pkg;

  // Opcodes; 0xA-0xE are undefined (and 0x8/0x9 when branches are disabled)
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_BEQZ = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_PASSA = 3'd5
  } alu_op_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  // Instruction field positions
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_LO  = 9;
  localparam int RA_LO  = 6;
  localparam int RB_LO  = 3;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// cpu_ctrl_decode: combinational instruction decoder.
//   ir        in   instruction register
//   rd/ra/rb  out  register address fields
//   imm8      out  immediate field ir[7:0]
//   aluOp     out  ALU function for the instruction
//   wbEn      out  instruction writes a register in WB
//   isLdi     out  write data comes from imm8 instead of the ALU
//   isBranch  out  BEQZ/JMP (only when CPU_BRANCH_EN is defined)
//   isHalt    out  HALT opcode
//   isIllegal out  undefined opcode, executed as NOP
// Macro CPU_BRANCH_EN: when undefined, opcodes 0x8/0x9 decode as illegal.
module cpu_ctrl_decode
  import cpu_pkg::*;
#(
  parameter int IR_W = 16,
  parameter int RA_W = 3
) (
  input  logic [IR_W-1:0] ir,
  output logic [RA_W-1:0] rd,
  output logic [RA_W-1:0] ra,
  output logic [RA_W-1:0] rb,
  output logic [7:0]      imm8,
  output alu_op_t         aluOp,
  output logic            wbEn,
  output logic            isLdi,
  output logic            isBranch,
  output logic            isHalt,
  output logic            isIllegal
);

  logic [3:0] op;

  assign op   = ir[OP_HI:OP_LO];
  assign rd   = ir[RD_LO +: RA_W];
  assign ra   = ir[RA_LO +: RA_W];
  assign rb   = ir[RB_LO +: RA_W];
  assign imm8 = ir[IMM_HI:IMM_LO];

  always_comb begin
    aluOp     = ALU_ADD;
    wbEn      = 1'b0;
    isLdi     = 1'b0;
    isBranch  = 1'b0;
    isHalt    = 1'b0;
    isIllegal = 1'b0;
    case (op)
      OP_NOP:  ;
      OP_ADD:  begin wbEn = 1'b1; aluOp = ALU_ADD; end
      OP_SUB:  begin wbEn = 1'b1; aluOp = ALU_SUB; end
      OP_AND:  begin wbEn = 1'b1; aluOp = ALU_AND; end
      OP_OR:   begin wbEn = 1'b1; aluOp = ALU_OR;  end
      OP_XOR:  begin wbEn = 1'b1; aluOp = ALU_XOR; end
      OP_LDI:  begin wbEn = 1'b1; isLdi = 1'b1; aluOp = ALU_PASSA; end
      OP_MOV:  begin wbEn = 1'b1; aluOp = ALU_PASSA; end
`ifdef CPU_BRANCH_EN
      // BEQZ tests RdDataA, so PASS_A keeps ra on the read port meaningful
      OP_BEQZ: begin isBranch = 1'b1; aluOp = ALU_PASSA; end
      OP_JMP:  isBranch = 1'b1;
`endif
      OP_HALT: isHalt = 1'b1;
      default: isIllegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: multi-cycle control sequencer for the 8-bit CPU.
// FETCH -> DECODE -> EXEC -> (WB) -> FETCH; HALT is absorbing until reset.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   imem_req/addr/rdata/ack  instruction fetch handshake (addr = pc)
//   RdAdrsA/B, RdDataA/B  RegFile read ports (addresses from ir[8:6]/ir[5:3])
//   alu_op, alu_result    external ALU function and result
//   LdReg/WtAdrs/WtData   RegFile write port, pulsed in WB
//   halted                high in HALT
//   illegal               one-cycle pulse in EXEC for an undefined opcode
// Macro CPU_BRANCH_EN: enables BEQZ/JMP; otherwise they are illegal opcodes.
module cpu_ctrl_seq
  import cpu_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8,
  parameter int RA_W   = 3,
  parameter int IR_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [IR_W-1:0]   imem_rdata,
  input  logic              imem_ack,
  output logic [RA_W-1:0]   RdAdrsA,
  output logic [RA_W-1:0]   RdAdrsB,
  input  logic [DATA_W-1:0] RdDataA,
  input  logic [DATA_W-1:0] RdDataB,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              LdReg,
  output logic [RA_W-1:0]   WtAdrs,
  output logic [DATA_W-1:0] WtData,
  output logic              halted,
  output logic              illegal
);

  state_t              state, stateNext;
  logic [PC_W-1:0]     pc;
  logic [IR_W-1:0]     ir;
  logic [DATA_W-1:0]   result;

  logic [RA_W-1:0]     rd, ra, rb;
  logic [7:0]          imm8;
  alu_op_t             aluOp;
  logic                wbEn, isLdi, isBranch, isHalt, isIllegal;

  cpu_ctrl_decode #(
    .IR_W (IR_W),
    .RA_W (RA_W)
  ) uDecode (
    .ir        (ir),
    .rd        (rd),
    .ra        (ra),
    .rb        (rb),
    .imm8      (imm8),
    .aluOp     (aluOp),
    .wbEn      (wbEn),
    .isLdi     (isLdi),
    .isBranch  (isBranch),
    .isHalt    (isHalt),
    .isIllegal (isIllegal)
  );

`ifdef CPU_BRANCH_EN
  logic branchTaken;
  assign branchTaken = isBranch && ((ir[OP_HI:OP_LO] == OP_JMP) || (RdDataA == '0));
  logic unusedRdB;
  assign unusedRdB = ^RdDataB;
`else
  logic unusedNoBranch;
  assign unusedNoBranch = ^{RdDataA, RdDataB, isBranch};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_FETCH;
      pc     <= '0;
      ir     <= '0;
      result <= '0;
    end else begin
      state <= stateNext;
      case (state)
        S_FETCH:  if (imem_ack) ir <= imem_rdata;
        S_DECODE: pc <= pc + PC_W'(1);
        S_EXEC: begin
          result <= isLdi ? DATA_W'(imm8) : alu_result;
`ifdef CPU_BRANCH_EN
          // pc already advanced in DECODE; a taken branch overwrites it here
          if (branchTaken) pc <= PC_W'(imm8);
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNext = state;
    imem_req  = 1'b0;
    LdReg     = 1'b0;
    illegal   = 1'b0;
    halted    = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) stateNext = S_DECODE;
      end
      S_DECODE: stateNext = S_EXEC;
      S_EXEC: begin
        illegal = isIllegal;
        if (isHalt)    stateNext = S_HALT;
        else if (wbEn) stateNext = S_WB;
        else           stateNext = S_FETCH;
      end
      S_WB: begin
        LdReg     = 1'b1;
        stateNext = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: stateNext = S_FETCH;
    endcase
  end

  assign imem_addr = pc;
  assign RdAdrsA   = ra;
  assign RdAdrsB   = rb;
  assign alu_op    = aluOp;
  assign WtAdrs    = rd;
  assign WtData    = result;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb_cpu_ctrl_seq: self-checking bench for cpu_ctrl_seq.
// Holds a RegFile, ALU and instruction memory around the DUT, plus an
// instruction-level model (architectural regs + pc) with a per-instruction
// cycle timeline that every cycle's outputs are compared against.
// Macro CPU_BRANCH_EN selects the branch-enabled expectations.
module tb_cpu_ctrl_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic [2:0]  RdAdrsA, RdAdrsB;
  logic [7:0]  RdDataA, RdDataB;
  logic [2:0]  alu_op;
  logic [7:0]  alu_result;
  logic        LdReg;
  logic [2:0]  WtAdrs;
  logic [7:0]  WtData;
  logic        halted;
  logic        illegal;

  always #5 clk = ~clk;

  cpu_ctrl_seq #(.PC_W(8), .DATA_W(8), .RA_W(3), .IR_W(16)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .RdAdrsA(RdAdrsA), .RdAdrsB(RdAdrsB), .RdDataA(RdDataA), .RdDataB(RdDataB),
    .alu_op(alu_op), .alu_result(alu_result),
    .LdReg(LdReg), .WtAdrs(WtAdrs), .WtData(WtData),
    .halted(halted), .illegal(illegal)
  );

  // Bench RegFile and ALU
  logic [7:0] rf [8];
  always_ff @(posedge clk) if (LdReg) rf[WtAdrs] <= WtData;
  assign RdDataA = rf[RdAdrsA];
  assign RdDataB = rf[RdAdrsB];
  always_comb begin
    case (alu_op)
      3'd0:    alu_result = RdDataA + RdDataB;
      3'd1:    alu_result = RdDataA - RdDataB;
      3'd2:    alu_result = RdDataA & RdDataB;
      3'd3:    alu_result = RdDataA | RdDataB;
      3'd4:    alu_result = RdDataA ^ RdDataB;
      default: alu_result = RdDataA;
    endcase
  end

  logic [15:0] imem [256];

`ifdef CPU_BRANCH_EN
  localparam logic [7:0] EXP_R2  = 8'h77;
  localparam int         EXP_ILL = 1;
`else
  localparam logic [7:0] EXP_R2  = 8'h03;
  localparam int         EXP_ILL = 3;
`endif

  // Model state
  logic [7:0] mRegs [8];
  logic [7:0] mPc;
  logic [7:0] mVal;
  logic [2:0] mRd, mRa, mRb;
  bit         busy, mHalt, mWrites, mIll, rstReq;
  int         age, fetchOrd, delayOrd, delayLen, waitLeft;
  int         cyc, firstLd, illCount;
  int         nAssert, nFail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    nAssert++;
    if (act !== want) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Architectural effect of one instruction
  task automatic execModel(input logic [15:0] w);
    logic [3:0] op;
    logic [7:0] a, b, val, nextPc;
    op = w[15:12];
    mRd = w[11:9]; mRa = w[8:6]; mRb = w[5:3];
    a = mRegs[mRa]; b = mRegs[mRb];
    val = 8'h00; nextPc = mPc + 8'd1;
    mWrites = 1'b0; mIll = 1'b0; mHalt = 1'b0;
    case (op)
      4'h0: ;
      4'h1: begin mWrites = 1'b1; val = a + b; end
      4'h2: begin mWrites = 1'b1; val = a - b; end
      4'h3: begin mWrites = 1'b1; val = a & b; end
      4'h4: begin mWrites = 1'b1; val = a | b; end
      4'h5: begin mWrites = 1'b1; val = a ^ b; end
      4'h6: begin mWrites = 1'b1; val = w[7:0]; end
      4'h7: begin mWrites = 1'b1; val = a; end
`ifdef CPU_BRANCH_EN
      4'h8: if (a == 8'h00) nextPc = w[7:0];
      4'h9: nextPc = w[7:0];
`else
      4'h8, 4'h9: mIll = 1'b1;
`endif
      4'hF: mHalt = 1'b1;
      default: mIll = 1'b1;
    endcase
    if (mWrites) mRegs[mRd] = val;
    mVal = val;
    mPc  = nextPc;
  endtask

  // One clock: compare outputs against the instruction timeline, then drive inputs.
  // Timeline after an accepted fetch: age 1 decode, 2 execute, 3 writeback/halt.
  task automatic step();
    bit expReq, expLd, expIll, expHalt;
    @(negedge clk);
    cyc++;
    reset = 1'b0;
    if (busy) begin
      age++;
      if (!mHalt && age == (mWrites ? 4 : 3)) busy = 1'b0;
    end
    expReq  = !busy;
    expLd   = busy && mWrites && age == 3;
    expIll  = busy && mIll && age == 2;
    expHalt = busy && mHalt && age >= 3;
    chk("imem_req", imem_req, expReq);
    chk("LdReg",    LdReg,    expLd);
    chk("illegal",  illegal,  expIll);
    chk("halted",   halted,   expHalt);
    if (expReq) chk("imem_addr", imem_addr, mPc);
    if (expLd) begin
      chk("WtAdrs", WtAdrs, mRd);
      chk("WtData", WtData, mVal);
    end
    if (busy && age >= 1 && age <= 3 && !expHalt) begin
      chk("RdAdrsA", RdAdrsA, mRa);
      chk("RdAdrsB", RdAdrsB, mRb);
    end
    if (LdReg === 1'b1 && firstLd == 0) firstLd = cyc;
    if (illegal === 1'b1) illCount++;

    imem_ack   = 1'b0;
    imem_rdata = 16'hF0F0;
    if (rstReq) begin
      // ack offered together with reset must be ignored
      rstReq = 1'b0; reset = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h6E11;
      busy = 1'b0; mHalt = 1'b0; age = 0; mPc = 8'h00;
      waitLeft = -1; fetchOrd = 0; cyc = 0; firstLd = 0; illCount = 0;
      return;
    end
    if (!busy) begin
      if (waitLeft < 0) waitLeft = (fetchOrd == delayOrd) ? delayLen : 0;
      if (waitLeft > 0) waitLeft--;
      else begin
        imem_ack = 1'b1; imem_rdata = imem[mPc];
        execModel(imem[mPc]);
        busy = 1'b1; age = 0; fetchOrd++; waitLeft = -1;
      end
    end else if (age == 1) begin
      // stray ack outside FETCH
      imem_ack = 1'b1; imem_rdata = 16'h6FFF;
    end
  endtask

  task automatic doReset();
    rstReq = 1'b1;
    step();
  endtask

  initial begin
    nAssert = 0; nFail = 0; cyc = 0; firstLd = 0; illCount = 0;
    busy = 1'b0; mHalt = 1'b0; mWrites = 1'b0; mIll = 1'b0; rstReq = 1'b0;
    age = 0; fetchOrd = 0; waitLeft = -1; mPc = 8'h00;
    mVal = 8'h00; mRd = 3'd0; mRa = 3'd0; mRb = 3'd0;
    for (int i = 0; i < 8; i++) mRegs[i] = 8'h00;
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0000;

    // Program A: ALU ops, MOV, NOP, illegal, branches, HALT; fetch #2 stalls 3 cycles
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
    imem[0]  = 16'h6205; // LDI r1,05
    imem[1]  = 16'h6403; // LDI r2,03
    imem[2]  = 16'h1650; // ADD r3,r1,r2
    imem[3]  = 16'h2888; // SUB r4,r2,r1
    imem[4]  = 16'h3A50; // AND r5,r1,r2
    imem[5]  = 16'h4C50; // OR  r6,r1,r2
    imem[6]  = 16'h5E50; // XOR r7,r1,r2
    imem[7]  = 16'h7100; // MOV r0,r4
    imem[8]  = 16'h0000; // NOP
    imem[9]  = 16'hB000; // undefined
    imem[10] = 16'h8040; // BEQZ r1,40 (r1=5)
    imem[11] = 16'h6200; // LDI r1,00
    imem[12] = 16'h8040; // BEQZ r1,40 (r1=0)
    imem[13] = 16'hF000; // HALT
    imem[8'h40] = 16'h9080; // JMP 80
    imem[8'h80] = 16'h6477; // LDI r2,77
    imem[8'h81] = 16'hF000; // HALT
    delayOrd = 2; delayLen = 3;

    repeat (4) step();
    chk("lit_first_ld", LdReg, 1'b1);
    chk("lit_ldi_adrs", WtAdrs, 3'd1);
    chk("lit_ldi_data", WtData, 8'h05);
    step();
    chk("lit_pc_after_ldi", imem_addr, 8'h01);
    for (int i = 0; i < 400 && !(busy && mHalt && age >= 5); i++) step();
    chk("progA_reached_halt", busy && mHalt && age >= 5, 1'b1);
    chk("lit_ld_cycle", firstLd, 4);
    chk("lit_r3_add", rf[3], 8'h08);
    chk("lit_r4_sub", rf[4], 8'hFE);
    chk("lit_r5_and", rf[5], 8'h01);
    chk("lit_r6_or",  rf[6], 8'h07);
    chk("lit_r7_xor", rf[7], 8'h06);
    chk("lit_r0_mov", rf[0], 8'hFE);
    chk("lit_r2",     rf[2], EXP_R2);
    chk("lit_ill_count", illCount, EXP_ILL);
    chk("lit_halt_req", imem_req, 1'b0);
    chk("lit_halted", halted, 1'b1);

    // Program B: pc wraps 0xFF -> 0x00, then reset during a stalled fetch
    doReset();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    imem[255] = 16'h6AA5; // LDI r5,A5
    delayOrd = 256; delayLen = 6;
    for (int i = 0; i < 1200 && !(fetchOrd == 256 && waitLeft >= 1 && waitLeft <= 3); i++) step();
    chk("progB_reached_wrap", fetchOrd, 256);
    chk("lit_wrap_addr", imem_addr, 8'h00);
    chk("lit_wrap_req", imem_req, 1'b1);
    chk("lit_r5_ldi", rf[5], 8'hA5);

    // Program C: reset while stalled at pc=2, then run to HALT
    doReset();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    imem[2] = 16'hF000;
    delayOrd = 2; delayLen = 5;
    for (int i = 0; i < 50 && !(fetchOrd == 2 && waitLeft >= 1 && waitLeft <= 3); i++) step();
    chk("lit_stall_addr", imem_addr, 8'h02);
    chk("lit_stall_ld", LdReg, 1'b0);
    delayOrd = -1;
    doReset();
    step();
    chk("lit_rst_addr", imem_addr, 8'h00);
    chk("lit_rst_req", imem_req, 1'b1);
    chk("lit_rst_halted", halted, 1'b0);
    for (int i = 0; i < 50 && !(busy && mHalt && age >= 10); i++) step();
    chk("lit_halt_sticky", halted, 1'b1);
    chk("lit_halt_noreq", imem_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
